// File: rtl/if_stage_pkg.sv
// Shared fetch-stage macros, types and helpers.
`ifndef IF_STAGE_DEFINES_SVH
`define IF_STAGE_DEFINES_SVH
`define RstEnable   1'b1
`define ZeroWord    32'h0000_0000
`define InstAddrBus 31:0
`define InstBus     31:0
`define IfStFetch   1'b0
`define IfStDrop    1'b1
`define PcStep      32'd4
`endif

package if_stage_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned INST_W   = 32;
    // Wide enough for a count of 0..4 entries.
    localparam int unsigned FQ_CNT_W = 3;

    typedef enum logic {
        ST_FETCH = `IfStFetch,
        ST_DROP  = `IfStDrop
    } if_state_e;

    typedef struct packed {
        logic [`InstAddrBus] pc;
        logic [`InstBus]     inst;
    } fq_entry_t;

    // Instructions are word aligned; the low two address bits are discarded.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/if_stage_fetch_queue.sv
// Small in-order FIFO of fetched {pc, inst} pairs; head is always entry 0.
module if_stage_fetch_queue
    import if_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic                flush_keep_head,
    input  fq_entry_t           push_data,
    output logic [FQ_CNT_W-1:0] count,
    output logic                head_valid,
    output fq_entry_t           head
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fq_entry_t           mem [DEPTH];
    logic [FQ_CNT_W-1:0] cnt_q;
    logic                has_room;

    assign has_room   = (cnt_q < FQ_CNT_W'(DEPTH));
    assign count      = cnt_q;
    assign head_valid = (cnt_q != '0);
    assign head       = mem[0];

    // Occupancy: flush keeps at most the head (and only if it is not popped).
    always_ff @(posedge clk) begin
        if (rst == `RstEnable) begin
            cnt_q <= '0;
        end else if (flush_keep_head) begin
            cnt_q <= ((cnt_q != '0) && !pop) ? FQ_CNT_W'(1) : '0;
        end else if (pop && !push) begin
            cnt_q <= cnt_q - FQ_CNT_W'(1);
        end else if (push && !pop && has_room) begin
            cnt_q <= cnt_q + FQ_CNT_W'(1);
        end
    end

    // Storage: pop shifts toward the head; push lands just behind the last live entry.
    always_ff @(posedge clk) begin
        if (!flush_keep_head) begin
            if (pop) begin
                for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                    mem[i] <= mem[i+1];
                end
            end
            if (push && pop) begin
                mem[IW'(cnt_q - FQ_CNT_W'(1))] <= push_data;
            end else if (push && has_room) begin
                mem[IW'(cnt_q)] <= push_data;
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, ROM handshake, fetch queue and redirect handling.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [`InstAddrBus] RESET_PC = 32'h0000_0000,
    parameter int unsigned         FQ_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                branch_flag,
    input  logic [`InstAddrBus] branch_target_addr,
    output logic                rom_req,
    output logic [`InstAddrBus] rom_addr,
    input  logic                rom_ack,
    input  logic [`InstBus]     rom_data,
    output logic [`InstAddrBus] if_pc,
    output logic [`InstBus]     if_inst,
    output logic                if_valid
);

    if_state_e           state_q;
    logic [`InstAddrBus] pc_q;
    logic [`InstAddrBus] drop_addr_q;
    logic                outstanding_q;

    logic [FQ_CNT_W-1:0] fq_count;
    logic                fq_head_valid;
    fq_entry_t           fq_head;
    fq_entry_t           fq_push_data;

    logic accept;
    logic consume;
    logic redirect;
    logic in_flight;
    logic fq_push;

    // Request and head outputs; all forced quiet while reset is held.
    always_comb begin
        rom_req  = 1'b0;
        rom_addr = `ZeroWord;
        if_valid = 1'b0;
        if_pc    = `ZeroWord;
        if_inst  = `ZeroWord;
        if (rst != `RstEnable) begin
            if (state_q == ST_DROP) begin
                rom_req  = 1'b1;
                rom_addr = drop_addr_q;
            end else begin
                rom_req  = outstanding_q | (fq_count < FQ_CNT_W'(FQ_DEPTH));
                rom_addr = pc_q;
            end
            if_valid = fq_head_valid;
            if (fq_head_valid) begin
                if_pc   = fq_head.pc;
                if_inst = fq_head.inst;
            end
        end
    end

    // Handshake and queue control strobes.
    always_comb begin
        consume   = if_valid & ~stall;
        redirect  = (rst != `RstEnable) & branch_flag & ~stall;
        accept    = (state_q == ST_FETCH) & rom_req & rom_ack;
        // A request acked this cycle has completed, so only an unacked one is in flight.
        in_flight = rom_req & ~rom_ack;
        fq_push   = accept & ~redirect;
        fq_push_data.pc   = pc_q;
        fq_push_data.inst = rom_data;
    end

    // PC, outstanding flag and FETCH/DROP state.
    always_ff @(posedge clk) begin
        if (rst == `RstEnable) begin
            pc_q          <= RESET_PC;
            state_q       <= ST_FETCH;
            outstanding_q <= 1'b0;
            drop_addr_q   <= `ZeroWord;
        end else begin
            outstanding_q <= in_flight;

            if (redirect) begin
                pc_q <= align_word(branch_target_addr);
            end else if (accept) begin
                pc_q <= pc_q + `PcStep;
            end

            case (state_q)
                ST_FETCH: begin
                    if (redirect && in_flight) begin
                        state_q     <= ST_DROP;
                        drop_addr_q <= rom_addr;
                    end
                end
                ST_DROP: begin
                    if (rom_ack) begin
                        state_q <= ST_FETCH;
                    end
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    // Delay-slot head is popped normally; everything behind it is flushed on redirect.
    if_stage_fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk             (clk),
        .rst             (rst),
        .push            (fq_push),
        .pop             (consume),
        .flush_keep_head (redirect),
        .push_data       (fq_push_data),
        .count           (fq_count),
        .head_valid      (fq_head_valid),
        .head            (fq_head)
    );

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage with a variable-latency ROM responder.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_flag;
    logic [31:0] branch_target_addr;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic        rom_ack;
    logic [31:0] rom_data;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned rom_lat = 0;
    int unsigned rom_wait = 0;
    logic        rom_spur = 1'b0;
    logic        prev_pend;
    logic [31:0] prev_addr;
    logic [31:0] sb_q [$];

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .FQ_DEPTH (2)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .stall              (stall),
        .branch_flag        (branch_flag),
        .branch_target_addr (branch_target_addr),
        .rom_req            (rom_req),
        .rom_addr           (rom_addr),
        .rom_ack            (rom_ack),
        .rom_data           (rom_data),
        .if_pc              (if_pc),
        .if_inst            (if_inst),
        .if_valid           (if_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1234};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // ROM: acks after rom_lat waiting cycles; optionally fires a stray ack with no request.
    initial begin
        rom_ack   = 1'b0;
        rom_data  = 32'h0;
        prev_pend = 1'b0;
        prev_addr = 32'h0;
        forever begin
            @(negedge clk);
            if (rom_req && prev_pend) chk("addr_hold", rom_addr, prev_addr);
            if (rom_req) begin
                if (rom_wait >= rom_lat) begin
                    rom_ack  = 1'b1;
                    rom_data = rom_word(rom_addr);
                    rom_wait = 0;
                end else begin
                    rom_ack  = 1'b0;
                    rom_data = 32'hDEAD_DEAD;
                    rom_wait++;
                end
            end else if (rom_spur) begin
                rom_ack  = 1'b1;
                rom_data = 32'hBAD0_BAD0;
                rom_wait = 0;
            end else begin
                rom_ack  = 1'b0;
                rom_wait = 0;
            end
            prev_pend = rom_req && !rom_ack;
            prev_addr = rom_addr;
        end
    end

    // Every consumed head must be the next expected PC with its ROM word.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && if_valid && !stall) begin
                if (sb_q.size() == 0) begin
                    chk("sb_extra", 32'(if_valid), 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    chk("head_pc", if_pc, e);
                    chk("head_inst", if_inst, rom_word(e));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; branch_target_addr = 32'h0;
        repeat (3) cyc();
        #1;
        chk("rst_req", 32'(rom_req), 32'h0);
        chk("rst_addr", rom_addr, 32'h0);
        chk("rst_valid", 32'(if_valid), 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_inst", if_inst, 32'h0);

        // Zero-wait ROM streaming
        rst = 1'b0; #1;
        chk("c0_req", 32'(rom_req), 32'h1);
        chk("c0_addr", rom_addr, 32'h0);
        chk("c0_valid", 32'(if_valid), 32'h0);
        sb_q.push_back(32'h0);  sb_q.push_back(32'h4);  sb_q.push_back(32'h8);
        sb_q.push_back(32'hC);  sb_q.push_back(32'h10);
        cyc(); #1;
        chk("c1_addr", rom_addr, 32'h4);
        chk("c1_pc", if_pc, 32'h0);
        chk("c1_inst", if_inst, rom_word(32'h0));
        cyc(); #1;
        chk("c2_addr", rom_addr, 32'h8);
        chk("c2_pc", if_pc, 32'h4);

        // Stall fills the queue; request stops while full
        cyc(); stall = 1'b1; #1;
        chk("c3_pc", if_pc, 32'h8);
        repeat (3) begin
            cyc(); #1;
            chk("full_req", 32'(rom_req), 32'h0);
            chk("full_pc", if_pc, 32'h8);
            chk("full_inst", if_inst, rom_word(32'h8));
        end
        cyc(); stall = 1'b0; #1;
        chk("c7_req", 32'(rom_req), 32'h0);
        cyc(); #1;
        chk("c8_pc", if_pc, 32'hC);
        chk("c8_addr", rom_addr, 32'h10);

        // Branch under stall is ignored; then redirect with a flushed 2nd entry
        cyc(); stall = 1'b1; branch_flag = 1'b1; branch_target_addr = 32'h0000_2000; #1;
        chk("c9_pc", if_pc, 32'h10);
        cyc(); stall = 1'b0; branch_target_addr = 32'h0000_0103; #1;
        chk("c10_req", 32'(rom_req), 32'h0);
        chk("c10_pc", if_pc, 32'h10);
        cyc(); branch_flag = 1'b0; #1;
        chk("c11_addr", rom_addr, 32'h100);
        chk("c11_valid", 32'(if_valid), 32'h0);
        sb_q.push_back(32'h100); sb_q.push_back(32'h104); sb_q.push_back(32'h108);

        // Two-cycle ROM latency
        cyc(); rom_lat = 2; #1;
        chk("c12_pc", if_pc, 32'h100);
        chk("c12_addr", rom_addr, 32'h104);
        cyc(); #1;
        chk("c13_valid", 32'(if_valid), 32'h0);
        chk("c13_req", 32'(rom_req), 32'h1);
        chk("c13_addr", rom_addr, 32'h104);
        cyc(); #1;
        chk("c14_valid", 32'(if_valid), 32'h0);
        chk("c14_addr", rom_addr, 32'h104);
        cyc(); #1;
        chk("c15_valid", 32'(if_valid), 32'h1);
        chk("c15_pc", if_pc, 32'h104);
        chk("c15_addr", rom_addr, 32'h108);
        cyc(); #1;
        chk("c16_valid", 32'(if_valid), 32'h0);
        cyc();
        cyc(); #1;
        chk("c18_pc", if_pc, 32'h108);

        // Redirect with a request for 0x10C in flight, then redirect again in DROP
        cyc(); rom_lat = 3; branch_flag = 1'b1; branch_target_addr = 32'h0000_0040; #1;
        chk("c19_valid", 32'(if_valid), 32'h0);
        chk("c19_addr", rom_addr, 32'h10C);
        sb_q.push_back(32'h48); sb_q.push_back(32'h4C);
        cyc(); branch_target_addr = 32'h0000_0048; #1;
        chk("drop_req", 32'(rom_req), 32'h1);
        chk("drop_addr", rom_addr, 32'h10C);
        cyc(); branch_flag = 1'b0; #1;
        chk("drop_addr2", rom_addr, 32'h10C);
        cyc(); #1;
        chk("resume_addr", rom_addr, 32'h48);
        chk("resume_valid", 32'(if_valid), 32'h0);
        repeat (3) cyc();
        cyc(); #1;
        chk("c26_valid", 32'(if_valid), 32'h1);
        chk("c26_pc", if_pc, 32'h48);
        repeat (4) cyc();

        // Fill under stall, redirect near the top of the address space
        cyc(); stall = 1'b1; rom_lat = 0;
        cyc();
        cyc(); #1;
        chk("c33_req", 32'(rom_req), 32'h0);
        chk("c33_pc", if_pc, 32'h50);
        cyc(); stall = 1'b0; branch_flag = 1'b1; branch_target_addr = 32'hFFFF_FFF8;
        sb_q.push_back(32'h50); sb_q.push_back(32'hFFFF_FFF8); sb_q.push_back(32'hFFFF_FFFC);
        cyc(); branch_flag = 1'b0; #1;
        chk("c35_addr", rom_addr, 32'hFFFF_FFF8);
        chk("c35_valid", 32'(if_valid), 32'h0);
        cyc(); #1;
        chk("c36_pc", if_pc, 32'hFFFF_FFF8);
        chk("c36_addr", rom_addr, 32'hFFFF_FFFC);
        cyc(); rom_lat = 3; #1;
        chk("c37_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_addr", rom_addr, 32'h0);
        chk("wrap_req", 32'(rom_req), 32'h1);

        // Reset in the middle of a request
        cyc(); rst = 1'b1; #1;
        chk("mid_rst_req", 32'(rom_req), 32'h0);
        chk("mid_rst_addr", rom_addr, 32'h0);
        chk("mid_rst_pc", if_pc, 32'h0);
        chk("mid_rst_inst", if_inst, 32'h0);
        chk("mid_rst_valid", 32'(if_valid), 32'h0);
        cyc(); #1;
        chk("mid_rst_req2", 32'(rom_req), 32'h0);
        cyc(); rst = 1'b0; rom_lat = 0; #1;
        chk("post_rst_addr", rom_addr, 32'h0);
        chk("post_rst_req", 32'(rom_req), 32'h1);
        chk("post_rst_valid", 32'(if_valid), 32'h0);
        sb_q.push_back(32'h0); sb_q.push_back(32'h4); sb_q.push_back(32'h8); sb_q.push_back(32'hC);
        cyc(); #1;
        chk("c41_pc", if_pc, 32'h0);

        // Stray ack while full and idle must be ignored
        cyc(); stall = 1'b1; #1;
        chk("c42_pc", if_pc, 32'h4);
        cyc(); rom_spur = 1'b1; #1;
        chk("spur_req", 32'(rom_req), 32'h0);
        cyc(); rom_spur = 1'b0; stall = 1'b0; #1;
        chk("c44_req", 32'(rom_req), 32'h0);
        chk("c44_pc", if_pc, 32'h4);
        cyc(); #1;
        chk("c45_pc", if_pc, 32'h8);
        cyc(); #1;
        chk("c46_pc", if_pc, 32'hC);
        cyc(); stall = 1'b1;
        repeat (3) cyc();

        chk("sb_left", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
